// File: rtl/fir_ctrl_pkg.sv
// Shared types for the FIR coefficient loader: controller states and tap-index width helper.
package fir_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ZFILL,
    DRAIN,
    FLUSH
  } fir_state_e;

  // Width able to hold 0..ntaps inclusive.
  function automatic int unsigned cw_of(input int unsigned ntaps);
    return $clog2(ntaps + 1);
  endfunction

endpackage

// File: rtl/fir_tap_writer.sv
// Registered tap-write port: strobe, index and data presented to the tap chain one cycle after request.
module fir_tap_writer #(
  parameter int unsigned CW = 3,
  parameter int unsigned TW = 12
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_wr,
  input  logic [CW-1:0] i_idx,
  input  logic [TW-1:0] i_data,
  output logic          o_tap_wr,
  output logic [CW-1:0] o_tap_idx,
  output logic [TW-1:0] o_tap_data
);

  logic          r_wr;
  logic [CW-1:0] r_idx;
  logic [TW-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wr   <= 1'b0;
      r_idx  <= '0;
      r_data <= '0;
    end else begin
      r_wr <= i_wr;
      if (i_wr) begin
        r_idx  <= i_idx;
        r_data <= i_data;
      end
    end
  end

  assign o_tap_wr   = r_wr;
  assign o_tap_idx  = r_idx;
  assign o_tap_data = r_data;

endmodule

// File: rtl/fir_coef_loader.sv
// Coefficient-reload controller for the systolic FIR chain; owns sample clock-enable and tap writes.
// Post-load delay-line flush is built only when FIR_FLUSH_EN is defined.
module fir_coef_loader
  import fir_ctrl_pkg::*;
#(
  parameter  int unsigned NTAPS = 5,
  parameter  int unsigned IW    = 12,
  parameter  int unsigned TW    = IW,
  localparam int unsigned CW    = cw_of(NTAPS)
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_coef_valid,
  output logic          o_coef_ready,
  input  logic [TW-1:0] i_coef,
  input  logic          i_coef_last,
  input  logic          i_sample_valid,
  output logic          o_sample_ready,
  input  logic [IW-1:0] i_sample,
  output logic          o_fir_ce,
  output logic [IW-1:0] o_fir_sample,
  output logic          o_tap_wr,
  output logic [CW-1:0] o_tap_idx,
  output logic [TW-1:0] o_tap_data,
  output logic          o_busy,
  output logic          o_err
);

  fir_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          r_busy;
  logic          r_coef_ready;

  fir_state_e    w_state_nxt;
  fir_state_e    w_done_state;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_err_nxt;
  logic          w_wr;
  logic [CW-1:0] w_idx;
  logic [TW-1:0] w_data;
  logic          w_accept;
  logic          w_last_idx;

  assign w_accept   = i_coef_valid && r_coef_ready;
  assign w_last_idx = (r_cnt == CW'(NTAPS - 1));

`ifdef FIR_FLUSH_EN
  assign w_done_state = FLUSH;
`else
  assign w_done_state = IDLE;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_coef_ready <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_err        <= w_err_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      r_coef_ready <= (w_state_nxt == LOAD) || (w_state_nxt == DRAIN);
    end
  end

  // Next-state, counter and tap-write request; r_cnt doubles as flush counter.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_wr        = 1'b0;
    w_idx       = r_cnt;
    w_data      = '0;
    case (r_state)
      IDLE: begin
        if (i_coef_valid) begin
          w_state_nxt = LOAD;
          w_cnt_nxt   = '0;
        end
      end
      LOAD: begin
        if (w_accept) begin
          w_wr      = 1'b1;
          w_data    = i_coef;
          w_cnt_nxt = r_cnt + CW'(1);
          if (i_coef_last && w_last_idx) begin
            w_err_nxt   = 1'b0;
            w_state_nxt = w_done_state;
            w_cnt_nxt   = '0;
          end else if (i_coef_last) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ZFILL;
          end else if (w_last_idx) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = DRAIN;
          end
        end
      end
      ZFILL: begin
        w_wr      = 1'b1;
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_last_idx) begin
          w_state_nxt = w_done_state;
          w_cnt_nxt   = '0;
        end
      end
      DRAIN: begin
        if (w_accept && i_coef_last) begin
          w_state_nxt = w_done_state;
          w_cnt_nxt   = '0;
        end
      end
      FLUSH: begin
        w_cnt_nxt = r_cnt + CW'(1);
        if (w_last_idx) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Sample path passes straight through in IDLE; zeros are pushed while flushing.
  assign o_sample_ready = i_reset_n && (r_state == IDLE);
  assign o_fir_ce       = i_reset_n && (((r_state == IDLE) && i_sample_valid) || (r_state == FLUSH));
  assign o_fir_sample   = (i_reset_n && (r_state == IDLE)) ? i_sample : '0;
  assign o_coef_ready   = r_coef_ready;
  assign o_busy         = r_busy;
  assign o_err          = r_err;

  fir_tap_writer #(
    .CW (CW),
    .TW (TW)
  ) u_tap_writer (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_wr       (w_wr),
    .i_idx      (w_idx),
    .i_data     (w_data),
    .o_tap_wr   (o_tap_wr),
    .o_tap_idx  (o_tap_idx),
    .o_tap_data (o_tap_data)
  );

endmodule
